// File: rtl/change_if.sv
// change_if: link between the ticket FSM (master) and the change dispenser (slave).
// Parameter: AMT_W - width of amount/remaining in dollars.
// Signals:
//   tick              pacing enable, one cycle per slow-clock period
//   start/amount      one-cycle payout request and its dollar amount
//   abort             one-cycle request to stop after the current coin
//   busy/done/err     dispenser status
//   coin_10/coin_5    coin-eject lines
//   remaining         dollars still to pay, plus its BCD tens/ones digits
//   tally_10/tally_5  completed-coin counters (only with CHANGE_TALLY_EN)
interface change_if #(
    parameter int unsigned AMT_W = 7
) ();
    logic             tick;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic             coin_10;
    logic             coin_5;
    logic [AMT_W-1:0] remaining;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
`ifdef CHANGE_TALLY_EN
    logic [7:0]       tally_10;
    logic [7:0]       tally_5;
`endif

    modport master (
        output tick, start, amount, abort,
        input  busy, done, err, coin_10, coin_5, remaining, bcd_tens, bcd_ones
`ifdef CHANGE_TALLY_EN
        , input tally_10, tally_5
`endif
    );

    modport slave (
        input  tick, start, amount, abort,
        output busy, done, err, coin_10, coin_5, remaining, bcd_tens, bcd_ones
`ifdef CHANGE_TALLY_EN
        , output tally_10, tally_5
`endif
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays a dollar amount out as serial coin-eject pulses,
// greedy order (10-dollar coins first, then 5-dollar coins).
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   chg_io  change_if slave: tick/start/amount/abort in; busy/done/err,
//           coin_10/coin_5, remaining and BCD digits out.
// Optional feature macro: CHANGE_TALLY_EN adds saturating 8-bit completed-coin
// counters tally_10/tally_5 on the interface.
module change_dispenser #(
    parameter int unsigned AMT_W       = 7,
    parameter int unsigned PULSE_TICKS = 2,
    parameter int unsigned GAP_TICKS   = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    change_if.slave  chg_io
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sel10_q, sel10_d;
    logic             abort_pend_q, abort_pend_d;
    logic             err_q, err_d;

    logic             start_ok;
    logic             pulse_last;
    logic             gap_last;
    logic             abort_any;
    logic [AMT_W-1:0] rem_after;

    always_comb begin
        start_ok   = (chg_io.amount <= AMT_W'(99)) && ((chg_io.amount % AMT_W'(5)) == '0);
        pulse_last = chg_io.tick && (cnt_q == 4'(PULSE_TICKS - 1));
        gap_last   = chg_io.tick && (cnt_q == 4'(GAP_TICKS - 1));
        // A live abort counts too, so one arriving on the last pulse tick still stops.
        abort_any  = abort_pend_q | chg_io.abort;
        rem_after  = rem_q - (sel10_q ? AMT_W'(10) : AMT_W'(5));
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rem_q        <= '0;
            sel10_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            sel10_q      <= sel10_d;
            abort_pend_q <= abort_pend_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (chg_io.start && start_ok) begin
                    state_d = (chg_io.amount == '0) ? StDone : StPulse;
                end
            end
            StPulse: begin
                // The pulse always runs to completion; abort is only acted on here.
                if (pulse_last) begin
                    state_d = ((rem_after == '0) || abort_any) ? StDone : StGap;
                end
            end
            StGap: begin
                if (abort_any) begin
                    state_d = StDone;
                end else if (gap_last) begin
                    state_d = StPulse;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        sel10_d      = sel10_q;
        abort_pend_d = abort_pend_q;
        err_d        = (state_q == StIdle) && chg_io.start && !start_ok;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (chg_io.tick && ((state_q == StPulse) || (state_q == StGap))) begin
            cnt_d = cnt_q + 4'd1;
        end

        if ((state_q == StIdle) && chg_io.start && start_ok) begin
            rem_d = chg_io.amount;
        end else if ((state_q == StPulse) && pulse_last) begin
            rem_d = rem_after;
        end

        // Coin choice is fixed on PULSE entry and held for the whole pulse.
        if ((state_d == StPulse) && (state_q != StPulse)) begin
            sel10_d = (state_q == StIdle) ? (chg_io.amount >= AMT_W'(10))
                                          : (rem_q >= AMT_W'(10));
        end

        if (state_q == StDone) begin
            abort_pend_d = 1'b0;
        end else if ((state_q != StIdle) && chg_io.abort) begin
            abort_pend_d = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        chg_io.busy      = (state_q != StIdle);
        chg_io.done      = (state_q == StDone);
        chg_io.err       = err_q;
        chg_io.coin_10   = (state_q == StPulse) && sel10_q;
        chg_io.coin_5    = (state_q == StPulse) && !sel10_q;
        chg_io.remaining = rem_q;
        chg_io.bcd_tens  = 4'(rem_q / AMT_W'(10));
        chg_io.bcd_ones  = 4'(rem_q % AMT_W'(10));
    end

`ifdef CHANGE_TALLY_EN
    logic [7:0] tally_10_q, tally_5_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tally_10_q <= '0;
            tally_5_q  <= '0;
        end else if ((state_q == StPulse) && pulse_last) begin
            if (sel10_q && (tally_10_q != 8'hff)) begin
                tally_10_q <= tally_10_q + 8'd1;
            end
            if (!sel10_q && (tally_5_q != 8'hff)) begin
                tally_5_q <= tally_5_q + 8'd1;
            end
        end
    end

    assign chg_io.tally_10 = tally_10_q;
    assign chg_io.tally_5  = tally_5_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser (AMT_W=7, PULSE_TICKS=2, GAP_TICKS=1).
module tb_change_dispenser;

    logic clk = 1'b0;
    logic rst_n;
    int   npass = 0;
    int   nchk  = 0;
    int   c5n, c10n, dn, en;

    // Expected per-cycle trace for a 35-dollar payout with tick every cycle.
    int exp_rem  [13] = '{35, 35, 25, 25, 25, 15, 15, 15, 5, 5, 5, 0, 0};
    int exp_c10  [13] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    int exp_c5   [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    int exp_done [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp_busy [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    change_if #(.AMT_W(7)) bus ();

    change_dispenser #(
        .AMT_W      (7),
        .PULSE_TICKS(2),
        .GAP_TICKS  (1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .chg_io(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.tick   = 1'b0;
        bus.start  = 1'b0;
        bus.amount = '0;
        bus.abort  = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_c10", bus.coin_10, 0);
        chk("rst_c5", bus.coin_5, 0);
        chk("rst_rem", bus.remaining, 0);
        step();
        step();

        // Normal payout of 35
        rst_n      = 1'b1;
        bus.tick   = 1'b1;
        bus.start  = 1'b1;
        bus.amount = 7'd35;
        for (int i = 0; i < 13; i++) begin
            step();
            bus.start = 1'b0;
            chk($sformatf("pay35_rem[%0d]", i), bus.remaining, exp_rem[i]);
            chk($sformatf("pay35_c10[%0d]", i), bus.coin_10, exp_c10[i]);
            chk($sformatf("pay35_c5[%0d]", i), bus.coin_5, exp_c5[i]);
            chk($sformatf("pay35_done[%0d]", i), bus.done, exp_done[i]);
            chk($sformatf("pay35_busy[%0d]", i), bus.busy, exp_busy[i]);
            if (i == 0) begin
                chk("pay35_bcd_tens", bus.bcd_tens, 3);
                chk("pay35_bcd_ones", bus.bcd_ones, 5);
            end
        end
        chk("pay35_end_tens", bus.bcd_tens, 0);
        chk("pay35_end_ones", bus.bcd_ones, 0);

        // Abort during the first 10-dollar coin of 40
        bus.start  = 1'b1;
        bus.amount = 7'd40;
        step();
        bus.start = 1'b0;
        chk("abort_c10_a", bus.coin_10, 1);
        chk("abort_rem_a", bus.remaining, 40);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_c10_b", bus.coin_10, 1);
        step();
        chk("abort_done", bus.done, 1);
        chk("abort_c10_c", bus.coin_10, 0);
        chk("abort_c5_c", bus.coin_5, 0);
        chk("abort_rem", bus.remaining, 30);
        step();
        chk("abort_idle_busy", bus.busy, 0);
        chk("abort_idle_rem", bus.remaining, 30);
        chk("abort_idle_c10", bus.coin_10, 0);
        chk("abort_bcd_tens", bus.bcd_tens, 3);
        chk("abort_bcd_ones", bus.bcd_ones, 0);

        // Reject 17 (not a multiple of 5)
        bus.start  = 1'b1;
        bus.amount = 7'd17;
        step();
        bus.start = 1'b0;
        chk("rej17_err", bus.err, 1);
        chk("rej17_busy", bus.busy, 0);
        chk("rej17_rem", bus.remaining, 30);
        chk("rej17_c10", bus.coin_10, 0);
        chk("rej17_c5", bus.coin_5, 0);
        step();
        chk("rej17_err_clr", bus.err, 0);
        chk("rej17_busy2", bus.busy, 0);

        // Reject 100 (too large)
        bus.start  = 1'b1;
        bus.amount = 7'd100;
        step();
        bus.start = 1'b0;
        chk("rej100_err", bus.err, 1);
        chk("rej100_busy", bus.busy, 0);
        chk("rej100_c10", bus.coin_10, 0);
        step();
        chk("rej100_err_clr", bus.err, 0);

        // Zero amount
        bus.start  = 1'b1;
        bus.amount = 7'd0;
        step();
        bus.start = 1'b0;
        chk("zero_done", bus.done, 1);
        chk("zero_err", bus.err, 0);
        chk("zero_c10", bus.coin_10, 0);
        chk("zero_c5", bus.coin_5, 0);
        step();
        chk("zero_done_clr", bus.done, 0);
        chk("zero_busy", bus.busy, 0);
        chk("zero_rem", bus.remaining, 0);

        // Asynchronous reset during a 5-dollar coin
        bus.start  = 1'b1;
        bus.amount = 7'd5;
        step();
        bus.start = 1'b0;
        chk("rstmid_c5_pre", bus.coin_5, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_c5", bus.coin_5, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_rem", bus.remaining, 0);
        #1 rst_n = 1'b1;
        step();
        bus.start  = 1'b1;
        bus.amount = 7'd10;
        step();
        bus.start = 1'b0;
        chk("post_rst_c10_a", bus.coin_10, 1);
        chk("post_rst_c5_a", bus.coin_5, 0);
        step();
        chk("post_rst_c10_b", bus.coin_10, 1);
        step();
        chk("post_rst_done", bus.done, 1);
        chk("post_rst_c10_c", bus.coin_10, 0);
        chk("post_rst_rem", bus.remaining, 0);
        step();
        chk("post_rst_busy", bus.busy, 0);

        // Sparse tick (every 4th cycle), 5 dollars, start while busy ignored
        c5n        = 0;
        c10n       = 0;
        dn         = 0;
        en         = 0;
        bus.tick   = 1'b0;
        bus.start  = 1'b1;
        bus.amount = 7'd5;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bus.coin_5 === 1'b1) c5n++;
            if (bus.coin_10 === 1'b1) c10n++;
            if (bus.done === 1'b1) dn++;
            if (bus.err === 1'b1) en++;
            if (i == 3) begin
                chk("sparse_busy_mid", bus.busy, 1);
                chk("sparse_c5_mid", bus.coin_5, 1);
                chk("sparse_rem_mid", bus.remaining, 5);
            end
            bus.start  = (i == 2);
            bus.amount = (i == 2) ? 7'd35 : 7'd5;
            bus.tick   = ((i % 4) == 0);
        end
        chk("sparse_c5_cycles", c5n, 8);
        chk("sparse_c10_cycles", c10n, 0);
        chk("sparse_done_count", dn, 1);
        chk("sparse_err_count", en, 0);
        chk("sparse_busy_end", bus.busy, 0);
        chk("sparse_rem_end", bus.remaining, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Consumer end of the ticket FSM's change interface.
- Accepts a change amount in dollars with a one-cycle start pulse.
- Pays the amount out as a serial train of discrete coin-eject pulses on the physical dispenser lines: 10-dollar coins first, then 5-dollar coins.
- Reports the remaining amount in binary and BCD for the 7-segment driver, and signals completion with a done pulse.

Parameters:
- AMT_W, 7, width of amount/remaining in dollars.
- PULSE_TICKS, 2, tick enables each coin line is held high (1..15).
- GAP_TICKS, 1, tick enables of low time between coins (1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; all state cleared while low.
- tick  input  1  one-cycle pacing enable (onepulse of slow divided clock); all coin timing counts tick cycles only.
- start  input  1  one-cycle request; sampled only in IDLE.
- amount  input  AMT_W  change in dollars, sampled with start.
- abort  input  1  one-cycle request to stop after the current coin.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse on completion or abort.
- err  output  1  one-cycle pulse on a rejected start.
- coin_10  output  1  eject 10-dollar coin, held PULSE_TICKS ticks.
- coin_5  output  1  eject 5-dollar coin, held PULSE_TICKS ticks.
- remaining  output  AMT_W  amount still to pay.
- bcd_tens  output  4  tens digit of remaining.
- bcd_ones  output  4  ones digit of remaining.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, err, coin_10, coin_5 = 0.
  - remaining = 0; tick counter = 0; abort_pending = 0.
  - Reset mid-coin drops the coin line immediately; the coin is not counted.
- States: IDLE, PULSE, GAP, DONE.
- IDLE, on start=1 (one-cycle latency to the next state):
  - amount > 99 or amount mod 5 != 0 → err=1 next cycle; stay IDLE; remaining unchanged.
  - amount == 0 → DONE; no coin issued.
  - Otherwise → remaining=amount, busy=1, enter PULSE.
- PULSE:
  - On entry, select the coin: remaining >= 10 → coin_10, else coin_5. Exactly one line is high; the selection is held for the whole pulse.
  - Count tick cycles. On the tick completing PULSE_TICKS: coin line low next cycle; remaining -= 10 or 5.
  - Then: remaining == 0 or abort_pending → DONE; else → GAP.
- GAP:
  - Both coin lines low; count GAP_TICKS ticks, then → PULSE.
  - abort_pending seen in GAP → DONE on the next clock, without waiting for ticks.
- DONE (one cycle):
  - done=1 for that cycle; busy is still 1 in that cycle.
  - Next cycle: IDLE, busy=0.
  - remaining holds its final value (0 on normal completion, residual after an abort) until the next accepted start.
- abort handling:
  - Latched into abort_pending while busy; cleared in DONE.
  - Ignored in IDLE.
  - A coin pulse already in progress is always completed, never truncated.
- start while busy: ignored; no err.
- start and abort in the same IDLE cycle: start is accepted, abort is ignored.
- tick during IDLE/DONE: ignored.
- Tick counter resets on every state entry.
- BCD: combinational from remaining; bcd_tens = remaining/10, bcd_ones = remaining%10. remaining never exceeds 99.
- Coin sequence: greedy, which yields the minimum coin count. Example: 35 → 10, 10, 10, 5.

Optional Feature:
- Macro: CHANGE_TALLY_EN.
- Defined:
  - Adds outputs tally_10[7:0] and tally_5[7:0].
  - Each counts completed coins of its type since reset.
  - Each increments in the same cycle remaining is decremented.
  - Each saturates at 255; cleared only by reset.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Normal payout (PULSE_TICKS=2, GAP_TICKS=1, tick every cycle): start, amount=35 →
  - Coin pattern: coin_10 ×3 then coin_5 ×1, each high 2 cycles with 1-cycle gaps.
  - remaining steps 35→25→15→5→0.
  - BCD 3/5 → 0/0; done once; busy low after done.
- Reject (non-multiple of 5): start, amount=17 → err pulse one cycle after start; busy never asserts; no coin; remaining unchanged.
- Reject (too large): start, amount=100 → err pulse; no coin.
- Zero amount: start, amount=0 → done one cycle after start; no coin; err=0.
- Abort mid-pulse: start, amount=40; abort during the first coin_10 →
  - That coin completes; remaining=30.
  - DONE with no further coins; next start accepted normally.
- Reset mid-pulse: reset=0 during coin_5 → coin_5, busy, remaining go 0 immediately without waiting for a clock edge; start with amount=10 after reset → single coin_10.
- Sparse tick (tick every 4th cycle): amount=5 → coin_5 high for exactly 2 tick periods; start during busy ignored.
